// File: rtl/sreg_shift_ctrl.sv
// Purpose: load+shift job controller for an external N-bit universal shift register (Moore FSM).
// Latency: cnt+2 cycles from the accept cycle to the done pulse; one IDLE cycle between jobs.
// Backpressure: start_ready is high only in IDLE; start_valid is ignored while a job runs.
//
// Ports:
//   clk, clr           clock, asynchronous active-low reset
//   start_valid/ready  job handshake (accept on rising edge when both high)
//   data, dir, cnt     job word, shift direction, shift count (saturated to N)
//   fill               serial fill bit for vacated positions
//   dout_r, dout_l     shift-register bit N-1 / bit 0 fed back (rotate build only)
//   M, p_load          mode (00 load, 01 toward bit 0, 10 toward bit N-1, 11 idle), load word
//   Din_R, Din_L       serial inputs entering bit 0 / bit N-1
//   busy, done         job in progress, one-cycle completion pulse
// Build option: define SREG_SHIFT_CTRL_ROTATE_EN to feed the shifted-out bit back in SHIFT
// (rotate); otherwise the captured fill bit drives both serial inputs.
module sreg_shift_ctrl #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [N-1:0]  data,
  input  logic          dir,
  input  logic [CW-1:0] cnt,
  input  logic          fill,
  input  logic          dout_r,
  input  logic          dout_l,
  output logic [1:0]    M,
  output logic [N-1:0]  p_load,
  output logic          Din_R,
  output logic          Din_L,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]    M_LOAD = 2'b00;
  localparam logic [1:0]    M_DN   = 2'b01;  // bit i <- bit i+1
  localparam logic [1:0]    M_UP   = 2'b10;  // bit i <- bit i-1
  localparam logic [1:0]    M_HOLD = 2'b11;
  localparam logic [CW-1:0] LP_N   = CW'(N);

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_data;
  logic          r_dir;
  logic          r_fill;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic [CW-1:0] w_cnt_sat;

  assign w_accept  = (r_state == S_IDLE) && start_valid;
  // More than N shifts would only push fill through again; saturate to N.
  assign w_cnt_sat = (cnt > LP_N) ? LP_N : cnt;

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Job capture and shift down-counter
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_data <= '0;
      r_dir  <= 1'b0;
      r_fill <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_data <= data;
      r_dir  <= dir;
      r_fill <= fill;
      r_cnt  <= w_cnt_sat;
    end else if (r_state == S_SHIFT) begin
      r_cnt  <= r_cnt - CW'(1);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_LOAD;
      S_LOAD:  w_next = (r_cnt != '0) ? S_SHIFT : S_DONE;
      // Counter holds the remaining shifts including this one; leave on the last.
      S_SHIFT: if (r_cnt <= CW'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode (registered state only, except rotate feedback in SHIFT)
  assign p_load = r_data;

  always_comb begin
    M           = M_HOLD;
    busy        = 1'b1;
    start_ready = 1'b0;
    done        = 1'b0;
    Din_R       = r_fill;
    Din_L       = r_fill;
    case (r_state)
      S_IDLE: begin
        busy        = 1'b0;
        start_ready = 1'b1;
      end
      S_LOAD:  M = M_LOAD;
      S_SHIFT: begin
        M = r_dir ? M_UP : M_DN;
`ifdef SREG_SHIFT_CTRL_ROTATE_EN
        // The bit leaving one end re-enters at the other end.
        if (r_dir) Din_R = dout_r;
        else       Din_L = dout_l;
`endif
      end
      S_DONE:  done = 1'b1;
      default: M = M_HOLD;
    endcase
  end

`ifndef SREG_SHIFT_CTRL_ROTATE_EN
  // Feedback bits are not needed when filling.
  logic w_unused_fb;
  assign w_unused_fb = dout_r ^ dout_l;
`endif

endmodule

// File: tb/tb_sreg_shift_ctrl.sv
module tb_sreg_shift_ctrl;
  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          clr;
  logic          start_valid;
  logic          start_ready;
  logic [N-1:0]  data;
  logic          dir;
  logic [CW-1:0] cnt;
  logic          fill;
  logic          dout_r;
  logic          dout_l;
  logic [1:0]    M;
  logic [N-1:0]  p_load;
  logic          Din_R;
  logic          Din_L;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  // Behavioural shift register driven by the controller.
  logic [N-1:0] sr;

  sreg_shift_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .clr(clr), .start_valid(start_valid), .start_ready(start_ready),
    .data(data), .dir(dir), .cnt(cnt), .fill(fill), .dout_r(dout_r), .dout_l(dout_l),
    .M(M), .p_load(p_load), .Din_R(Din_R), .Din_L(Din_L), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dout_r = sr[N-1];
  assign dout_l = sr[0];

  always @(posedge clk) begin
    case (M)
      2'b00: sr <= p_load;
      2'b01: sr <= {Din_L, sr[N-1:1]};
      2'b10: sr <= {sr[N-2:0], Din_R};
      default: sr <= sr;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dir;
    logic [3:0] cnt;
    logic       fill;
    logic [7:0] exp_fill;   // final register, fill build
    logic [7:0] exp_rot;    // final register, rotate build
    int         shifts;
  } vec_t;

  vec_t vt[8];

  // Runs one job; samples are taken 1 time unit after each rising edge.
  // Sample 0 is the LOAD cycle (the accept cycle precedes it), so done is
  // expected at sample shifts+1, i.e. cnt+2 cycles counting the accept cycle.
  task automatic run_job(input vec_t v);
    int s;
    int nload;
    int nright;
    int nwrong;
    int badp;
    int lat;
    logic [7:0] exp_reg;
    s = 0;
    while (!start_ready && s < 20) begin
      @(posedge clk); #1;
      s++;
    end
    chk("ready_before_job", {31'd0, start_ready}, 32'd1);
    data = v.data; dir = v.dir; cnt = v.cnt; fill = v.fill;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    // Inputs change after accept; the running job must not see them.
    data = ~v.data; dir = ~v.dir; cnt = 4'($urandom); fill = ~v.fill;
    nload = 0; nright = 0; nwrong = 0; badp = 0; lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (M == 2'b00) begin
        nload++;
        if (p_load !== v.data) badp++;
      end
      if (M == (v.dir ? 2'b10 : 2'b01)) nright++;
      if (M == (v.dir ? 2'b01 : 2'b10)) nwrong++;
      @(posedge clk); #1;
    end
    chk("done_latency", 32'(lat), 32'(v.shifts + 1));
    chk("load_cycles", 32'(nload), 32'd1);
    chk("load_word", 32'(badp), 32'd0);
    chk("shift_cycles", 32'(nright), 32'(v.shifts));
    chk("wrong_dir_cycles", 32'(nwrong), 32'd0);
`ifdef SREG_SHIFT_CTRL_ROTATE_EN
    exp_reg = v.exp_rot;
`else
    exp_reg = v.exp_fill;
`endif
    chk("final_register", {24'd0, sr}, {24'd0, exp_reg});
    chk("done_mode", {30'd0, M}, 32'd3);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {30'd0, start_ready, busy}, 32'd2);
    chk("p_load_held", {24'd0, p_load}, {24'd0, v.data});
    chk("din_fill", {30'd0, Din_R, Din_L}, {30'd0, v.fill, v.fill});
  endtask

  logic [1:0] tm[20];
  logic       td[20];
  logic       tr[20];
  logic       tbz[20];

  initial begin
    int nloads;
    int overlap;
    int gotdone;
    //            data   dir  cnt    fill  fill-exp rot-exp shifts
    vt[0] = '{8'hA5, 1'b0, 4'd3,  1'b0, 8'h14, 8'hB4, 3};
    vt[1] = '{8'h3C, 1'b1, 4'd0,  1'b0, 8'h3C, 8'h3C, 0};
    vt[2] = '{8'h12, 1'b1, 4'd15, 1'b1, 8'hFF, 8'h12, 8};
    vt[3] = '{8'h81, 1'b1, 4'd2,  1'b0, 8'h04, 8'h06, 2};
    vt[4] = '{8'hF0, 1'b0, 4'd9,  1'b0, 8'h00, 8'hF0, 8};
    vt[5] = '{8'h5A, 1'b0, 4'd1,  1'b1, 8'hAD, 8'h2D, 1};
    vt[6] = '{8'h81, 1'b0, 4'd1,  1'b0, 8'h40, 8'hC0, 1};
    vt[7] = '{8'h81, 1'b0, 4'd8,  1'b0, 8'h00, 8'h81, 8};

    clr = 1'b0; start_valid = 1'b0; data = '0; dir = 1'b0; cnt = '0; fill = 1'b0;

    // Reset state, sampled while clr is still low.
    #12;
    chk("rst_M", {30'd0, M}, 32'd3);
    chk("rst_p_load", {24'd0, p_load}, 32'd0);
    chk("rst_din", {30'd0, Din_R, Din_L}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, start_ready}, 32'd1);
    #10 clr = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_job(vt[i]);

    // Reset during the second SHIFT cycle abandons the job immediately.
    data = 8'hA5; dir = 1'b0; cnt = 4'd5; fill = 1'b1;
    start_valid = 1'b1;
    @(posedge clk); #1;          // LOAD
    start_valid = 1'b0;
    @(posedge clk); #1;          // SHIFT 1
    @(posedge clk); #1;          // SHIFT 2
    chk("mid_job_in_shift", {30'd0, M}, 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("clr_M", {30'd0, M}, 32'd3);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_ready", {31'd0, start_ready}, 32'd1);
    chk("clr_p_load", {24'd0, p_load}, 32'd0);
    gotdone = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) gotdone++;
    end
    #2 clr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) gotdone++;
    end
    chk("clr_no_done", 32'(gotdone), 32'd0);
    chk("clr_idle_after", {30'd0, start_ready, busy}, 32'd2);

    // start_valid held high: job = LOAD, SHIFT, DONE, then one IDLE cycle.
    data = 8'h0F; dir = 1'b1; cnt = 4'd1; fill = 1'b0;
    start_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      tm[k] = M; td[k] = done; tr[k] = start_ready; tbz[k] = busy;
    end
    start_valid = 1'b0;
    nloads = 0; overlap = 0;
    for (int k = 0; k < 20; k++) begin
      if (tm[k] == 2'b00) nloads++;
      if (tr[k] == tbz[k]) overlap++;
      if (td[k] && k + 2 < 20) begin
        chk("held_idle_gap", {29'd0, tm[k+1], tr[k+1]}, 32'h7);
        chk("held_next_load", {30'd0, tm[k+2]}, 32'd0);
      end
    end
    chk("held_load_count", 32'(nloads), 32'd5);
    chk("held_ready_vs_busy", 32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/sreg_shift_ctrl.md
SREG_SHIFT_CTRL -- requirements
Module: sreg_shift_ctrl

Interface
REQ-001 Parameter: N, default 8, width of the controlled shift register.
REQ-002 Parameter: CW, default 4, shift-count width; SHALL satisfy 2^CW > N.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 start_valid  input  1  request to run one load+shift job.
REQ-006 start_ready  output  1  controller can accept a job.
REQ-007 data  input  N  word to parallel-load.
REQ-008 dir  input  1  0 = shift toward bit 0 (mode 01); 1 = shift toward bit N-1 (mode 10).
REQ-009 cnt  input  CW  number of shift cycles after the load.
REQ-010 fill  input  1  serial fill bit for vacated positions.
REQ-011 dout_r, dout_l  input  1 each  shift-register bit N-1 and bit 0 outputs, fed back.
REQ-012 M  output  2  mode to the shift register: 00 load, 01 bit i <- bit i+1, 10 bit i <- bit i-1, 11 idle.
REQ-013 p_load  output  N  parallel-load word.
REQ-014 Din_R, Din_L  output  1 each  serial inputs entering bit 0 and bit N-1.
REQ-015 busy  output  1  job in progress; done  output  1  one-cycle job-complete pulse.

Function
REQ-016 FSM states: IDLE, LOAD, SHIFT, DONE; all outputs SHALL be decoded from registered state only (Moore).
REQ-017 IDLE: start_ready=1, busy=0, M=11; a job is accepted on a rising edge where start_valid=1 and start_ready=1.
REQ-018 On accept, data, dir, fill and cnt SHALL be captured; cnt values greater than N SHALL be captured as N.
REQ-019 LOAD lasts exactly one cycle: M=00 and p_load = captured data.
REQ-020 LOAD -> SHIFT when captured cnt != 0; LOAD -> DONE when it equals 0 (load-only job).
REQ-021 SHIFT lasts exactly cnt cycles: M=01 if dir=0, M=10 if dir=1; the down-counter decrements once per cycle, and the state exits when the counter reaches 1.
REQ-022 DONE lasts one cycle: done=1, M=11; then IDLE.
REQ-023 busy=1 in LOAD, SHIFT and DONE; start_ready=0 in those states, and start_valid SHALL be ignored there.
REQ-024 p_load SHALL hold the last captured word in every state; its reset value is 0.
REQ-025 Din_R and Din_L SHALL both equal the captured fill outside the rotate mode (see Configuration).
REQ-026 Accept-to-done latency: cnt+2 cycles; back-to-back jobs SHALL be separated by exactly one IDLE cycle.
REQ-027 Input changes after the accept edge SHALL NOT affect the running job.

Reset
REQ-028 clr low SHALL force IDLE at once, from any state and without waiting for clk.
REQ-029 Reset values: M=11, p_load=0, Din_R=0, Din_L=0, busy=0, done=0, start_ready=1, counter=0.
REQ-030 When reset is asserted mid-job, the job SHALL be abandoned and no done pulse SHALL be produced.

Configuration
REQ-031 Macro SREG_SHIFT_CTRL_ROTATE_EN selects rotate behaviour.
REQ-032 With the macro defined, SHIFT with dir=0 SHALL drive Din_L=dout_l; SHIFT with dir=1 SHALL drive Din_R=dout_r. The shift register then rotates, and fill is ignored in SHIFT.
REQ-033 Without the macro, dout_r and dout_l SHALL be ignored and the fill behaviour of REQ-025 applies.

Verification
REQ-034 After reset, data=8'hA5, dir=0, cnt=3, fill=0, pulse start_valid -> 1 LOAD cycle (M=00, p_load=A5), 3 cycles M=01, done at accept+5; shift register=8'h14.
REQ-035 dir=1, cnt=0, data=8'h3C -> LOAD then DONE, no M=01/10 cycle, register=8'h3C, done at accept+2.
REQ-036 cnt=15 with N=8 -> exactly 8 SHIFT cycles; with fill=1 and dir=1, register=8'hFF.
REQ-037 clr driven low during the second SHIFT cycle -> immediate M=11, busy=0, start_ready=1, no done pulse.
REQ-038 start_valid held high continuously -> jobs accepted only in IDLE, one IDLE cycle between done and the next LOAD.
REQ-039 With SREG_SHIFT_CTRL_ROTATE_EN: data=8'h81, dir=0, cnt=1 -> register=8'hC0; cnt=8 -> register returns to 8'h81.
